alu_sched: RTL
==============

Name: alu_sched

Overview:
Two-requester scheduler that time-shares one 32-bit combinational ALU (8 ops, carry/overflow/zero flags). Arbitrates requests round-robin and drives the registered ALU operand/selector inputs. Waits a programmable settle time to absorb gate delay, then captures result and flags into a per-requester response channel. Sits between the register-file/decode logic and the shared ALU instance.

Parameters:
SETTLE_CYCLES, 4, clocks between operand launch and result capture; legal range 1..15
CNT_W, 16, width of optional grant-statistics counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  3  opcode: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7
req0_a, req0_b  in  32 each  operands
req1_valid, req1_ready, req1_op, req1_a, req1_b  as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes result
rsp0_result  out  32  captured ALU output
rsp0_flags  out  3  {carry, overflow, zero}
rsp1_valid, rsp1_ready, rsp1_result, rsp1_flags  as requester 0
alu_a, alu_b  out  32 each  registered ALU operands
alu_sel  out  3  registered ALU selector
alu_out  in  32  ALU result
alu_carry, alu_ovf, alu_zero  in  1 each  ALU flags
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0 (req*_ready, rsp*_valid, rsp*_result, rsp*_flags, alu_a, alu_b, alu_sel, busy); round-robin pointer = requester 0. Reset mid-transaction drops the operation; no response is produced.
- States: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE: grant = pointer requester if its valid is high, else the other if valid. reqN_ready = (state==IDLE) && grantN (combinational from valid). On handshake: latch op/a/b into alu_sel/alu_a/alu_b, record owner, load settle counter with SETTLE_CYCLES-1, go SETTLE. No valid: stay IDLE.
- SETTLE: counter decrements each clock. At count 0, capture alu_out and {alu_carry, alu_ovf, alu_zero} into owner's rsp regs; set rspN_valid; go RESP.
- Latency: handshake at edge T -> rspN_valid high after edge T+SETTLE_CYCLES.
- RESP: hold rspN_valid, result, and flags stable until rspN_ready is high at an edge. Then clear rspN_valid, set pointer to the non-owner, return to IDLE. Next grant is possible the cycle after.
- alu_a/alu_b/alu_sel hold their values after capture until the next grant.
- Only one transaction is ever in flight. Both req*_ready are 0 outside IDLE, so the other requester stalls.
- Simultaneous valids: pointer requester wins. Pointer advances only on response completion, which guarantees alternation under continuous contention.
- Flags are passed through unmodified. Logic ops return carry=overflow=0 as produced by the ALU.
- The requester's operands need only be stable during the handshake cycle.

Optional Feature:
ALU_SCHED_STATS_EN. When defined, adds outputs grant0_cnt and grant1_cnt [CNT_W-1:0]. Each increments on its requester's handshake, saturates at all-ones, and clears on reset. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_sched_pkg: opcode constants (ADD..OR, values 0..7), state encoding (IDLE/SETTLE/RESP), and flag bit indices (CARRY=2, OVF=1, ZERO=0).
- One sub-module, rr_arb2: 2-way round-robin grant logic. Inputs: pointer and two valids; outputs: one-hot grant.

Test Plan:
- After reset, req0 ADD a=10 b=1 -> req0_ready 1 cycle; rsp0_valid at T+4; result 0x0000000B; flags 000.
- req1 SUB a=0 b=1 -> rsp1_result 0xFFFFFFFF; flags 000. req1 XOR a=1 b=1 -> result 0; flags 001.
- Both valid in the same cycle after reset, each issuing ADD 1+1 continuously -> grants alternate req0, req1, req0; never two consecutive grants to one requester.
- rsp0_ready held low 6 cycles -> rsp0_valid/result stable throughout; req1_ready stays 0; req1 is granted the cycle after rsp0 completes.
- rst_n low during SETTLE -> next cycle all outputs 0 and state IDLE; no rsp*_valid ever fires for the dropped op.
- With ALU_SCHED_STATS_EN: 3 req0 and 2 req1 transactions -> grant0_cnt=3, grant1_cnt=2; with CNT_W=2, 5 req0 transactions -> grant0_cnt saturates at 3.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared definitions for the two-requester ALU scheduler.
// Holds the opcode values understood by the shared ALU, the scheduler state
// encoding, the response flag bit positions and a flag packing helper.
package alu_sched_pkg;

  // Opcodes presented on alu_sel
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  // Bit positions inside the 3-bit response flag field
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  // Settle counter width; covers the full 1..15 settle range
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Place the ALU flag wires at their response bit positions
  function automatic logic [2:0] pack_flags(input logic carry,
                                            input logic ovf,
                                            input logic zero);
    logic [2:0] f;
    f = 3'b000;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
// The requester named by ptr wins when it is asking; otherwise the other
// requester is granted if it is asking. Output is one-hot or zero.
module rr_arb2 (
  input  logic       ptr,
  input  logic       valid0,
  input  logic       valid1,
  output logic [1:0] grant
);

  // Pointer requester has priority, the other one fills idle slots
  always_comb begin
    grant = 2'b00;
    if (!ptr) begin
      if (valid0)      grant = 2'b01;
      else if (valid1) grant = 2'b10;
    end else begin
      if (valid1)      grant = 2'b10;
      else if (valid0) grant = 2'b01;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: time-shares one external combinational 32-bit ALU between two
// requesters. One operation is in flight at a time: operands are registered
// onto the ALU, the scheduler waits SETTLE_CYCLES clocks for the ALU to
// settle, then captures result and flags into the owner's response channel.
//
// Optional build macro: ALU_SCHED_STATS_EN adds saturating per-requester
// grant counters (grant0_cnt, grant1_cnt, CNT_W bits wide).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation in flight; requesters may be granted
// SETTLE  | operands launched, counting down until the ALU output is good
// RESP    | response held for the owner until it is taken
import alu_sched_pkg::*;

module alu_sched #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [31:0]       req0_a,
  input  logic [31:0]       req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [31:0]       req1_a,
  input  logic [31:0]       req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [31:0]       rsp0_result,
  output logic [2:0]        rsp0_flags,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [31:0]       rsp1_result,
  output logic [2:0]        rsp1_flags,

  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_sel,
  input  logic [31:0]       alu_out,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_zero,

  output logic              busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt
`endif
);

  // Reject settle times the counter cannot represent and empty counters
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || CNT_W < 1) begin : g_param_check
    $error("alu_sched: SETTLE_CYCLES must be 1..15 and CNT_W at least 1");
  end

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic                ptr;
  logic                owner;
  logic [SETTLE_W-1:0] cnt;
  logic [1:0]          grant;
  logic                hs0;
  logic                hs1;
  logic [2:0]          cap_flags;

  rr_arb2 u_arb (
    .ptr    (ptr),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant  (grant)
  );

  // Ready is only offered while idle; gating with rst_n keeps it low in reset
  assign hs0 = rst_n && (state == ST_IDLE) && grant[0];
  assign hs1 = rst_n && (state == ST_IDLE) && grant[1];
  assign req0_ready = hs0;
  assign req1_ready = hs1;

  assign cap_flags = pack_flags(alu_carry, alu_ovf, alu_zero);

  // Scheduler FSM: grant, launch operands, settle, capture, hand back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hs0) begin
            owner   <= 1'b0;
            alu_sel <= req0_op;
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            cnt     <= SETTLE_LOAD;
            state   <= ST_SETTLE;
            busy    <= 1'b1;
          end else if (hs1) begin
            owner   <= 1'b1;
            alu_sel <= req1_op;
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            cnt     <= SETTLE_LOAD;
            state   <= ST_SETTLE;
            busy    <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            if (!owner) begin
              rsp0_valid  <= 1'b1;
              rsp0_result <= alu_out;
              rsp0_flags  <= cap_flags;
            end else begin
              rsp1_valid  <= 1'b1;
              rsp1_result <= alu_out;
              rsp1_flags  <= cap_flags;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Pointer moves to the other requester only once a response is
          // taken, so continuous contention alternates strictly
          if (!owner && rsp0_ready) begin
            rsp0_valid <= 1'b0;
            ptr        <= 1'b1;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end else if (owner && rsp1_ready) begin
            rsp1_valid <= 1'b0;
            ptr        <= 1'b0;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Saturating grant counters, one per requester
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (hs0 && (grant0_cnt != {CNT_W{1'b1}}))
        grant0_cnt <= grant0_cnt + CNT_W'(1);
      if (hs1 && (grant1_cnt != {CNT_W{1'b1}}))
        grant1_cnt <= grant1_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
